// File: rtl/serial_frame_rx.sv
// Serial frame receiver (start, WIDTH data bits, optional even parity with SERIAL_FRAME_RX_PARITY_EN, stop) into a one-entry valid/ready register.
// out_valid rises 1 clk after the stop-bit sample; a full, unaccepted output register drops the new frame and pulses overrun.
`timescale 1ns/1ps
module serial_frame_rx #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             si,
  input  logic             msb_first,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic par_bad_q;
  logic parity_err_q;
  assign parity_err = parity_err_q;
`else
  localparam state_t AFTER_DATA = STOP;
  assign parity_err = 1'b0;
`endif

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] out_data_q;
  logic             msb_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             out_free;

  // The bit order latched at the start bit decides which end the line enters.
  always_comb begin
    shift_d = shift_q;
    if (msb_q) shift_d = {shift_q[WIDTH-2:0], si};
    else       shift_d = {si, shift_q[WIDTH-1:1]};
  end

  assign out_free = !out_valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      out_data_q   <= '0;
      msb_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (!si) begin
              msb_q   <= msb_first;
              cnt_q   <= '0;
              state_q <= DATA;
              busy_q  <= 1'b1;
            end
          end
          DATA: begin
            shift_q <= shift_d;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_q <= AFTER_DATA;
          end
`ifdef SERIAL_FRAME_RX_PARITY_EN
          PARITY: begin
            par_bad_q <= ^{shift_q, si};
            state_q   <= STOP;
          end
`endif
          STOP: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!si) begin
              frame_err_q <= 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            end else if (par_bad_q) begin
              parity_err_q <= 1'b1;
`endif
            end else if (out_free) begin
              out_data_q  <= shift_q;
              out_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial frame receiver: the receive end of the serial output produced by the team's universal shift-register transmit path. Detects a start bit on `si`, deserializes WIDTH data bits (LSB-first or MSB-first), checks the stop bit (and optionally parity), and presents the word through a one-entry valid/ready output register. Sits between a serial link and any parallel consumer.

## Interface
- WIDTH, 5, data bits per frame; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- bit_en  input  1  bit-rate strobe; the line is sampled and state advances only on cycles with bit_en=1.
- si  input  1  serial line; idles high.
- msb_first  input  1  bit order: 0 = LSB-first, 1 = MSB-first; captured on the start-bit sample and held for the frame.
- out_data  output  WIDTH  received word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word on any cycle with out_valid=1 and out_ready=1.
- busy  output  1  high in any state other than IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 when parity is compiled out.
- overrun  output  1  one-cycle pulse: good frame dropped because the output register was full.

## Operation
- Reset (rst_n=0, asynchronous): state IDLE, bit count 0, shift register 0, out_data 0, out_valid 0, busy 0, all error pulses 0. Reset mid-frame abandons the frame; no error pulses.
- Frame on the line: start (0), WIDTH data bits, parity bit (PARITY_EN only), stop (1). One bit per bit_en.
- States: IDLE -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: on bit_en with si=0, latch msb_first, clear bit count, go DATA. si=1 stays IDLE.
- DATA: on each bit_en shift si in. LSB-first: shift right, si enters bit WIDTH-1 (first bit ends at bit 0). MSB-first: shift left, si enters bit 0 (first bit ends at bit WIDTH-1). After the WIDTH-th bit go PARITY (or STOP).
- PARITY: on bit_en compare si against even parity of the received word (XOR of data and parity bit must be 0); record mismatch; go STOP.
- STOP: on bit_en, always return to IDLE, and:
  - si=0: frame_err pulse; word discarded (parity check not reported).
  - si=1 with parity mismatch: parity_err pulse; word discarded.
  - si=1, clean, output register free (out_valid=0, or out_valid=1 with out_ready=1 on the same edge): load out_data, out_valid=1.
  - si=1, clean, out_valid=1 and out_ready=0: overrun pulse; new word dropped; out_data unchanged.
- Output handshake: out_valid clears on the edge where out_valid=1 and out_ready=1, unless a new word loads on that same edge (then stays 1 with new data). out_data is stable while out_valid=1 and out_ready=0.
- bit_en=0 cycles hold all state (handshake still operates).
- After frame_err the receiver re-arms immediately in IDLE; a continued 0 on the next bit_en is taken as a new start.

## Timing
- All outputs registered; changes are visible the cycle after the causing edge.
- Latency: out_valid rises 1 clk after the bit_en edge that samples the stop bit.
- Frame length: WIDTH+2 bit_en strobes (WIDTH+3 with PARITY_EN).
- Error pulses are exactly one clk wide regardless of bit_en rate.
- bit_en may be held high continuously (one bit per clk); back-to-back frames with no idle bit are accepted.

## Configuration
- SERIAL_FRAME_RX_PARITY_EN defined: PARITY state present; frame carries an even-parity bit after the data; parity_err functional.
- Not defined: no PARITY state; DATA goes directly to STOP; parity_err held 0.

## Test plan
- Reset mid-frame: send start plus 2 data bits, pull rst_n low between edges -> all outputs 0 immediately; next clean frame received correctly.
- LSB-first, bit_en=1 every clk, WIDTH=5, bits 0,1,1,0,1 (parity 1 if enabled), stop 1 -> out_data=5'b10110, out_valid high 1 clk after stop sample.
- Same line bits with msb_first=1 -> out_data=5'b01101.
- Stop bit 0 -> frame_err one-cycle pulse, out_valid stays 0, following frame 5'b00011 received.
- Parity build: data 5'b10110 with parity bit 0 -> parity_err pulse, no out_valid; with macro undefined, same frame minus parity bit -> accepted.
- out_ready=0, two clean frames 5'h0A then 5'h15 -> overrun pulse on second stop, out_data stays 5'h0A; repeat with out_ready=1 on the second stop edge -> no overrun, out_data=5'h15, out_valid stays 1.
